lstm_param_loader: RTL and testbench

LSTM_PARAM_LOADER -- requirements
Module: lstm_param_loader

---
 rtl/lstm_pkg.sv | 21 ++
 rtl/lstm_param_loader.sv | 126 ++++++++++++
 tb/tb_lstm_param_loader.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/lstm_pkg.sv
// Shared types for the LSTM parameter path: gate count, word kinds and loader states.
// Kind order matches the order the parameter stream carries them inside each layer.
package lstm_pkg;

  localparam int WEIGHTS = 4;

  typedef enum logic [1:0] {
    KIND_WX,
    KIND_WH,
    KIND_BX,
    KIND_BH
  } lstm_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE,
    ST_ERROR
  } loader_state_e;

endpackage

// File: rtl/lstm_param_loader.sv
// Streams LAYERS*16 signed words into the weight/bias registers of a stacked LSTM.
// Latency: word and its one-cycle strobe appear the cycle after the beat is accepted.
// Backpressure: s_ready high only while loading; a mis-framed stream ends the load in ERROR.
module lstm_param_loader
  import lstm_pkg::*;
#(
  parameter int LAYERS = 3,
  parameter int WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [WIDTH-1:0]               s_data,
  input  logic                           s_valid,
  input  logic                           s_last,
  output logic                           s_ready,
  output logic signed [WIDTH-1:0]        weight_x [LAYERS*WEIGHTS],
  output logic signed [WIDTH-1:0]        weight_h [LAYERS*WEIGHTS],
  output logic signed [WIDTH-1:0]        bias_x   [LAYERS*WEIGHTS],
  output logic signed [WIDTH-1:0]        bias_h   [LAYERS*WEIGHTS],
  output logic [LAYERS*WEIGHTS-1:0]      weight_x_valid,
  output logic [LAYERS*WEIGHTS-1:0]      weight_h_valid,
  output logic [LAYERS*WEIGHTS-1:0]      bias_x_valid,
  output logic [LAYERS*WEIGHTS-1:0]      bias_h_valid,
  output logic                           busy,
  output logic                           done,
  output logic                           error
);

  localparam int N  = LAYERS * 4 * WEIGHTS;
  localparam int M  = LAYERS * WEIGHTS;
  localparam int CW = $clog2(N);
  localparam int IW = $clog2(M);

  loader_state_e state;
  logic [CW-1:0] cnt;

  logic [IW-1:0] widx;
  lstm_kind_e    wkind;
  logic          at_end;

  // Word k: layer in the bits above 4, kind in bits [3:2], gate in bits [1:0].
  always_comb begin
    widx   = IW'({cnt >> 4, cnt[1:0]});
    wkind  = lstm_kind_e'(cnt[3:2]);
    at_end = (cnt == CW'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      s_ready        <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      weight_x_valid <= '0;
      weight_h_valid <= '0;
      bias_x_valid   <= '0;
      bias_h_valid   <= '0;
      for (int i = 0; i < M; i++) begin
        weight_x[i] <= '0;
        weight_h[i] <= '0;
        bias_x[i]   <= '0;
        bias_h[i]   <= '0;
      end
    end else begin
      weight_x_valid <= '0;
      weight_h_valid <= '0;
      bias_x_valid   <= '0;
      bias_h_valid   <= '0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state   <= ST_LOAD;
            cnt     <= '0;
            s_ready <= 1'b1;
            busy    <= 1'b1;
            done    <= 1'b0;
            error   <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (s_valid) begin
            // A beat is good only when s_last agrees with being the final word.
            if (s_last == at_end) begin
              case (wkind)
                KIND_WX: begin
                  weight_x[widx]       <= s_data;
                  weight_x_valid[widx] <= 1'b1;
                end
                KIND_WH: begin
                  weight_h[widx]       <= s_data;
                  weight_h_valid[widx] <= 1'b1;
                end
                KIND_BX: begin
                  bias_x[widx]       <= s_data;
                  bias_x_valid[widx] <= 1'b1;
                end
                KIND_BH: begin
                  bias_h[widx]       <= s_data;
                  bias_h_valid[widx] <= 1'b1;
                end
              endcase
              if (at_end) begin
                state   <= ST_DONE;
                done    <= 1'b1;
                s_ready <= 1'b0;
                busy    <= 1'b0;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end else begin
              state   <= ST_ERROR;
              error   <= 1'b1;
              s_ready <= 1'b0;
              busy    <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lstm_param_loader.sv
// Directed + randomized bench for lstm_param_loader against a flat stream-order memory model.
module tb_lstm_param_loader;
  import lstm_pkg::*;

  localparam int LAYERS = 3;
  localparam int WIDTH  = 16;
  localparam int M      = LAYERS * WEIGHTS;
  localparam int N      = M * 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst     = 1'b1;
  logic             start   = 1'b0;
  logic [WIDTH-1:0] s_data  = '0;
  logic             s_valid = 1'b0;
  logic             s_last  = 1'b0;
  logic             s_ready;
  logic signed [WIDTH-1:0] weight_x [M];
  logic signed [WIDTH-1:0] weight_h [M];
  logic signed [WIDTH-1:0] bias_x   [M];
  logic signed [WIDTH-1:0] bias_h   [M];
  logic [M-1:0] weight_x_valid, weight_h_valid, bias_x_valid, bias_h_valid;
  logic busy, done, error;

  lstm_param_loader #(.LAYERS(LAYERS), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .weight_x(weight_x), .weight_h(weight_h), .bias_x(bias_x), .bias_h(bias_h),
    .weight_x_valid(weight_x_valid), .weight_h_valid(weight_h_valid),
    .bias_x_valid(bias_x_valid), .bias_h_valid(bias_h_valid),
    .busy(busy), .done(done), .error(error)
  );

  int checks = 0;
  int errors = 0;
  int strobes_seen = 0;

  // Reference: parameters held in stream order; loader status as plain flags.
  logic [WIDTH-1:0] mem [N];
  logic [N-1:0]     m_strobe;
  bit               m_loading, m_done, m_err;
  int               m_k;

  function automatic logic [WIDTH-1:0] dut_word(input int k);
    int idx;
    idx = (k / 16) * WEIGHTS + k % 4;
    case ((k / 4) % 4)
      0:       return weight_x[idx];
      1:       return weight_h[idx];
      2:       return bias_x[idx];
      default: return bias_h[idx];
    endcase
  endfunction

  function automatic logic dut_strobe(input int k);
    int idx;
    idx = (k / 16) * WEIGHTS + k % 4;
    case ((k / 4) % 4)
      0:       return weight_x_valid[idx];
      1:       return weight_h_valid[idx];
      2:       return bias_x_valid[idx];
      default: return bias_h_valid[idx];
    endcase
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0] os;
    int bad_k;
    bad_k = -1;
    for (int k = 0; k < N; k++) begin
      os[k] = dut_strobe(k);
      if (bad_k < 0 && dut_word(k) !== mem[k]) bad_k = k;
    end
    strobes_seen += $countones(os);
    checks++;
    assert (bad_k === -1) else begin
      errors++;
      $error("FAIL %s words: word %0d observed %h expected %h", tag, bad_k,
             dut_word(bad_k), mem[bad_k]);
    end
    checks++;
    assert (os === m_strobe) else begin
      errors++;
      $error("FAIL %s strobes: observed %h expected %h", tag, os, m_strobe);
    end
    checks++;
    assert ({s_ready, busy, done, error} === {m_loading, m_loading, m_done, m_err}) else begin
      errors++;
      $error("FAIL %s flags(rdy,busy,done,err): observed %b expected %b", tag,
             {s_ready, busy, done, error}, {m_loading, m_loading, m_done, m_err});
    end
    checks++;
    assert (($countones(os) <= 1) === 1'b1) else begin
      errors++;
      $error("FAIL %s onehot: observed %0d strobes expected at most 1", tag, $countones(os));
    end
  endtask

  task automatic tick(input logic st, input logic v, input logic [WIDTH-1:0] d,
                      input logic l, input logic r, input string tag);
    start = st; s_valid = v; s_data = d; s_last = l; rst = r;
    @(posedge clk);
    m_strobe = '0;
    if (r) begin
      m_loading = 0; m_k = 0; m_done = 0; m_err = 0;
      for (int i = 0; i < N; i++) mem[i] = '0;
    end else if (!m_loading) begin
      if (st) begin
        m_loading = 1; m_k = 0; m_done = 0; m_err = 0;
      end
    end else if (v) begin
      if (l && m_k == N - 1) begin
        mem[m_k] = d; m_strobe[m_k] = 1'b1; m_loading = 0; m_done = 1;
      end else if (l || m_k == N - 1) begin
        m_loading = 0; m_err = 1;
      end else begin
        mem[m_k] = d; m_strobe[m_k] = 1'b1; m_k++;
      end
    end
    #1;
    check_all(tag);
  endtask

  // mode 0: well framed, 1: s_last early at err_k, 2: s_last missing on final word.
  task automatic run_load(input int mode, input int err_k, input int gap, input bit alt,
                          input bit rnd_data, input int start_at);
    logic [WIDTH-1:0] d;
    logic l;
    tick(1'b1, 1'b0, '0, 1'b0, 1'b0, "start");
    for (int k = 0; k < N; k++) begin
      if (alt) tick(1'b0, 1'b0, WIDTH'($urandom), 1'($urandom_range(0, 1)), 1'b0, "alt_gap");
      for (int g = 0; g < 3 && int'($urandom_range(0, 99)) < gap; g++)
        tick(1'b0, 1'b0, WIDTH'($urandom), 1'($urandom_range(0, 1)), 1'b0, "gap");
      l = (mode == 0) ? (k == N - 1) : (mode == 1) ? (k == err_k) : 1'b0;
      d = rnd_data ? WIDTH'($urandom) : WIDTH'(k + 1);
      tick(k == start_at, 1'b1, d, l, 1'b0, "beat");
      if (mode == 1 && k == err_k) break;
    end
    repeat (2) tick(1'b0, 1'b0, '0, 1'b0, 1'b0, "idle");
  endtask

  initial begin
    logic [WIDTH-1:0] d;
    m_loading = 0; m_done = 0; m_err = 0; m_k = 0; m_strobe = '0;
    for (int i = 0; i < N; i++) mem[i] = '0;

    // Reset state, and reset beating a coincident start.
    tick(1'b0, 1'b0, '0, 1'b0, 1'b1, "reset");
    tick(1'b1, 1'b1, 16'h1234, 1'b0, 1'b1, "rst_vs_start");
    tick(1'b0, 1'b1, 16'h5555, 1'b1, 1'b0, "idle_beat");

    // Back-to-back load, data = k+1.
    strobes_seen = 0;
    run_load(0, 0, 0, 1'b0, 1'b0, -1);
    chk("bias_h11", int'(bias_h[11]), 48);
    chk("weight_x4", int'(weight_x[4]), 17);
    chk("strobes_b2b", strobes_seen, 48);
    chk("done_b2b", int'(done), 1);

    // Same load with s_valid every other cycle.
    strobes_seen = 0;
    run_load(0, 0, 0, 1'b1, 1'b0, -1);
    chk("strobes_alt", strobes_seen, 48);
    chk("done_alt", int'(done), 1);
    tick(1'b0, 1'b1, 16'hdead, 1'b1, 1'b0, "done_beat");

    // Early s_last at word 10 after reset.
    tick(1'b0, 1'b0, '0, 1'b0, 1'b1, "reset2");
    run_load(1, 10, 0, 1'b0, 1'b0, -1);
    chk("err_early", int'(error), 1);
    chk("rdy_early", int'(s_ready), 0);
    chk("bias_x2_discarded", int'(bias_x[2]), 0);
    chk("bias_x1_written", int'(bias_x[1]), 10);
    chk("bias_h11_zero", int'(bias_h[11]), 0);

    // Missing s_last on the final word, then a good load recovers.
    run_load(2, 0, 0, 1'b0, 1'b0, -1);
    chk("err_nolast", int'(error), 1);
    chk("bias_h11_kept", int'(bias_h[11]), 0);
    run_load(0, 0, 20, 1'b0, 1'b1, -1);
    chk("done_recover", int'(done), 1);
    chk("err_recover", int'(error), 0);

    // Reset after 20 beats, coincident with a beat.
    tick(1'b1, 1'b0, '0, 1'b0, 1'b0, "start_rst");
    for (int k = 0; k < 20; k++) begin
      d = WIDTH'($urandom);
      tick(1'b0, 1'b1, d, 1'b0, 1'b0, "beat_rst");
    end
    tick(1'b0, 1'b1, 16'h7777, 1'b0, 1'b1, "rst_mid");
    chk("rdy_after_rst", int'(s_ready), 0);
    chk("wx0_after_rst", int'(weight_x[0]), 0);

    // start during LOAD at k=5 is ignored.
    run_load(0, 0, 10, 1'b0, 1'b1, 5);
    chk("done_start_ignored", int'(done), 1);

    // Randomized loads with gaps, random framing faults and stray starts.
    for (int t = 0; t < 8; t++) begin
      run_load(int'($urandom_range(0, 2)), int'($urandom_range(0, N - 2)), 25, 1'b0, 1'b1,
               int'($urandom_range(0, N + 10)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
